// File: rtl/raster_scheduler_if.sv
// rtl/raster_scheduler_if.sv - triangle stream handshake between producer and scheduler
interface raster_scheduler_if #(
    parameter int DATA_WIDTH = 4
);
    logic                  tri_valid;
    logic                  tri_ready;
    logic                  tri_last;
    logic [9:0]            tri_x0;
    logic [9:0]            tri_y0;
    logic [9:0]            tri_x1;
    logic [9:0]            tri_y1;
    logic [9:0]            tri_x2;
    logic [9:0]            tri_y2;
    logic [DATA_WIDTH-1:0] tri_color;

    modport master (
        output tri_valid, tri_last, tri_x0, tri_y0, tri_x1, tri_y1, tri_x2, tri_y2, tri_color,
        input  tri_ready
    );

    modport slave (
        input  tri_valid, tri_last, tri_x0, tri_y0, tri_x1, tri_y1, tri_x2, tri_y2, tri_color,
        output tri_ready
    );
endinterface

// File: rtl/raster_scheduler.sv
// rtl/raster_scheduler.sv - frame controller: clears framebuffer, feeds triangles to rasterizer
module raster_scheduler #(
    parameter int                       FB_WIDTH      = 160,
    parameter int                       FB_HEIGHT     = 120,
    parameter int                       FB_ADDR_WIDTH = 15,
    parameter int                       FB_DATA_WIDTH = 4,
    parameter logic [FB_DATA_WIDTH-1:0] CLEAR_VALUE   = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_start,
    raster_scheduler_if.slave        tri_stream,
    output logic [9:0]               rast_x0,
    output logic [9:0]               rast_y0,
    output logic [9:0]               rast_x1,
    output logic [9:0]               rast_y1,
    output logic [9:0]               rast_x2,
    output logic [9:0]               rast_y2,
    output logic                     rast_start,
    input  logic [FB_ADDR_WIDTH-1:0] rast_fb_addr,
    input  logic                     rast_fb_we,
    input  logic                     rast_done,
    output logic [FB_ADDR_WIDTH-1:0] fb_addr,
    output logic [FB_DATA_WIDTH-1:0] fb_data,
    output logic                     fb_we,
    output logic                     busy,
    output logic                     frame_done,
    output logic [15:0]              tri_count
);

    localparam logic [FB_ADDR_WIDTH-1:0] LAST_ADDR = FB_ADDR_WIDTH'(FB_WIDTH * FB_HEIGHT - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCEPT,
        LAUNCH,
        WAIT_RAST,
        FRAME_DONE
    } state_t;

    state_t                   state;
    logic [FB_ADDR_WIDTH-1:0] clear_addr;
    logic [FB_DATA_WIDTH-1:0] color_q;
    logic                     last_q;
    logic                     first_wait;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            clear_addr <= '0;
            tri_count  <= '0;
            color_q    <= '0;
            last_q     <= 1'b0;
            first_wait <= 1'b0;
            rast_x0    <= '0;
            rast_y0    <= '0;
            rast_x1    <= '0;
            rast_y1    <= '0;
            rast_x2    <= '0;
            rast_y2    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state      <= CLEAR;
                        clear_addr <= '0;
                        tri_count  <= '0;
                    end
                end
                CLEAR: begin
                    clear_addr <= clear_addr + 1'b1;
                    if (clear_addr == LAST_ADDR) begin
                        state <= ACCEPT;
                    end
                end
                ACCEPT: begin
                    if (tri_stream.tri_valid) begin
                        rast_x0 <= tri_stream.tri_x0;
                        rast_y0 <= tri_stream.tri_y0;
                        rast_x1 <= tri_stream.tri_x1;
                        rast_y1 <= tri_stream.tri_y1;
                        rast_x2 <= tri_stream.tri_x2;
                        rast_y2 <= tri_stream.tri_y2;
                        color_q <= tri_stream.tri_color;
                        last_q  <= tri_stream.tri_last;
                        if (tri_count != 16'hFFFF) begin
                            tri_count <= tri_count + 16'd1;
                        end
                        state <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    state      <= WAIT_RAST;
                    first_wait <= 1'b1;
                end
                WAIT_RAST: begin
                    // rast_done may still be high from the previous triangle during the first cycle
                    first_wait <= 1'b0;
                    if (!first_wait && rast_done) begin
                        state <= last_q ? FRAME_DONE : ACCEPT;
                    end
                end
                FRAME_DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign tri_stream.tri_ready = (state == ACCEPT);
    assign rast_start           = (state == LAUNCH);
    assign busy                 = (state != IDLE);
    assign frame_done           = (state == FRAME_DONE);

    always_comb begin
        fb_addr = '0;
        fb_data = '0;
        fb_we   = 1'b0;
        case (state)
            CLEAR: begin
                fb_addr = clear_addr;
                fb_data = CLEAR_VALUE;
                fb_we   = 1'b1;
            end
            WAIT_RAST: begin
                fb_addr = rast_fb_addr;
                fb_data = color_q;
                fb_we   = rast_fb_we;
            end
            default: begin
                fb_addr = '0;
                fb_data = '0;
                fb_we   = 1'b0;
            end
        endcase
    end

endmodule
